// File: rtl/clip_round_sched.sv
// Round-robin scheduler sharing one clip-and-round datapath among NUM_REQ valid/ready streams.
// Optional per-requester saturation counters: define CLIP_ROUND_SCHED_STATS_EN.
module clip_round_sched #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned bits_in   = 24,
    parameter int unsigned bits_out  = 16,
    parameter int unsigned clip_bits = 0,
    parameter int unsigned ID_W      = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_last,
    input  logic [NUM_REQ*bits_in-1:0]  req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        out_valid,
    output logic [bits_out-1:0]         out_data,
    output logic [ID_W-1:0]             out_id,
    output logic                        out_last,
`ifdef CLIP_ROUND_SCHED_STATS_EN
    output logic [NUM_REQ*16-1:0]       sat_count,
`endif
    input  logic                        out_ready
);

    localparam int unsigned MidW  = bits_in - clip_bits;
    localparam int unsigned DropW = MidW - bits_out;
    localparam int unsigned SelW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {StIdle, StLock} state_e;

    state_e              state_q;
    logic [ID_W-1:0]     grant_q;
    logic [ID_W-1:0]     rr_ptr_q;
    logic [ID_W-1:0]     pick_idx;
    logic                pick_valid;
    logic [SelW-1:0]     g_sel;
    logic                out_free;
    logic                accept;
    logic [bits_in-1:0]  sel_data;
    logic [MidW-1:0]     mid;
    logic [bits_out-1:0] cr_out;

    assign g_sel    = grant_q[SelW-1:0];
    assign out_free = !out_valid || out_ready;
    assign accept   = |(req_valid & req_ready);
    assign sel_data = req_data[32'(g_sel) * bits_in +: bits_in];

    // First pending requester at or after rr_ptr, wrapping upward.
    always_comb begin
        int unsigned j;
        j          = 0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            j = (32'(rr_ptr_q) + i) % NUM_REQ;
            if (!pick_valid && req_valid[j[SelW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = ID_W'(j);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == StLock && out_free) begin
            req_ready[g_sel] = 1'b1;
        end
    end

    // Saturate the clip_bits MSBs: they must all equal the sign bit.
    always_comb begin
        mid = sel_data[MidW-1:0];
        if (sel_data[bits_in-1 -: clip_bits+1] != {(clip_bits+1){sel_data[bits_in-1]}}) begin
            mid = {sel_data[bits_in-1], {(MidW-1){~sel_data[bits_in-1]}}};
        end
    end

    // Round half up, then clamp the single possible positive overflow.
    if (DropW > 0) begin : g_round
        localparam logic [MidW:0] Half = (MidW+1)'(1) << (DropW - 1);
        logic [bits_out:0] q;
        assign q      = (bits_out+1)'(({mid[MidW-1], mid} + Half) >> DropW);
        assign cr_out = (q[bits_out] != q[bits_out-1]) ? {1'b0, {(bits_out-1){1'b1}}}
                                                       : q[bits_out-1:0];
    end else begin : g_pass
        assign cr_out = mid[bits_out-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            out_last  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        grant_q <= pick_idx;
                        state_q <= StLock;
                    end
                end
                StLock: begin
                    if (accept && req_last[g_sel]) begin
                        rr_ptr_q <= (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= cr_out;
                out_id    <= grant_q;
                out_last  <= req_last[g_sel];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef CLIP_ROUND_SCHED_STATS_EN
    logic        is_sat;
    logic [15:0] sat_cnt_q [NUM_REQ];

    assign is_sat = (cr_out == {1'b0, {(bits_out-1){1'b1}}}) ||
                    (cr_out == {1'b1, {(bits_out-1){1'b0}}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                sat_cnt_q[k] <= '0;
            end
        end else if (accept && is_sat && sat_cnt_q[g_sel] != 16'hFFFF) begin
            sat_cnt_q[g_sel] <= sat_cnt_q[g_sel] + 16'd1;
        end
    end

    always_comb begin
        sat_count = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sat_count[k*16 +: 16] = sat_cnt_q[k];
        end
    end
`endif

endmodule

// File: tb/tb_clip_round_sched.sv
// Bench for clip_round_sched: two instances (clip_bits 0 and 1) share stimulus and are checked
// every cycle against a transaction-level model, plus hand-computed expectations per scenario.
module tb_clip_round_sched;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_last = '0;
    logic [95:0] req_data = '0;
    logic        out_ready = 1'b1;

    logic [3:0]  rdy0, rdy1;
    logic        ov0, ov1, ol0, ol1;
    logic [15:0] od0, od1;
    logic [1:0]  oid0, oid1;
`ifdef CLIP_ROUND_SCHED_STATS_EN
    logic [63:0] sat0, sat1;
`endif

    always #5 clk = ~clk;

    clip_round_sched #(.NUM_REQ(4), .bits_in(24), .bits_out(16), .clip_bits(0), .ID_W(2)) dut0 (
`ifdef CLIP_ROUND_SCHED_STATS_EN
        .sat_count(sat0),
`endif
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
        .req_data(req_data), .req_ready(rdy0), .out_valid(ov0), .out_data(od0),
        .out_id(oid0), .out_last(ol0), .out_ready(out_ready)
    );

    clip_round_sched #(.NUM_REQ(4), .bits_in(24), .bits_out(16), .clip_bits(1), .ID_W(2)) dut1 (
`ifdef CLIP_ROUND_SCHED_STATS_EN
        .sat_count(sat1),
`endif
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
        .req_data(req_data), .req_ready(rdy1), .out_valid(ov1), .out_data(od1),
        .out_id(oid1), .out_last(ol1), .out_ready(out_ready)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arithmetic in plain integers: clamp to the post-clip range, round half up,
    // clamp again to the output range.
    function automatic logic [15:0] cr(input logic [23:0] din, input int clipb);
        longint v, lim, r;
        int drop;
        v    = longint'($signed(din));
        lim  = longint'(1) <<< (23 - clipb);
        if (v >= lim) v = lim - 1;
        if (v < -lim) v = -lim;
        drop = 8 - clipb;
        r    = (v + (longint'(1) <<< (drop - 1))) >>> drop;
        if (r > 32767) r = 32767;
        return r[15:0];
    endfunction

    function automatic bit is_sat(input logic [15:0] d);
        return d == 16'h7FFF || d == 16'h8000;
    endfunction

    // Transaction model state.
    bit          m_locked = 0, n_locked;
    int          m_grant = 0, n_grant;
    int          m_ptr = 0, n_ptr;
    bit          m_ov = 0, n_ov;
    logic [15:0] m_d0 = '0, m_d1 = '0, n_d0, n_d1;
    int          m_id = 0, n_id;
    bit          m_last = 0, n_last;
    bit          n_inc0, n_inc1;
    int          m_sat0 [4] = '{0, 0, 0, 0};
    int          m_sat1 [4] = '{0, 0, 0, 0};

    logic [3:0]  e_rdy, a_vec;
    logic [23:0] m_din;

    int          log_id [$];
    logic [15:0] log_d0 [$];
    logic [15:0] log_d1 [$];
    bit          log_last [$];
    int          log_cyc [$];

    always @(negedge clk) begin
        cyc++;
        n_inc0 = 0;
        n_inc1 = 0;
        if (rst_n) begin
            e_rdy = (m_locked && (!m_ov || out_ready)) ? 4'(1 << m_grant) : 4'b0;
            chk("req_ready", 64'(rdy0), 64'(e_rdy));
            chk("req_ready_c1", 64'(rdy1), 64'(e_rdy));
            chk("out_valid", 64'(ov0), 64'(m_ov));
            chk("out_valid_c1", 64'(ov1), 64'(m_ov));
            chk("out_data", 64'(od0), 64'(m_d0));
            chk("out_data_c1", 64'(od1), 64'(m_d1));
            chk("out_id", 64'(oid0), 64'(m_id));
            chk("out_id_c1", 64'(oid1), 64'(m_id));
            chk("out_last", 64'(ol0), 64'(m_last));
            chk("out_last_c1", 64'(ol1), 64'(m_last));
`ifdef CLIP_ROUND_SCHED_STATS_EN
            for (int k = 0; k < 4; k++) begin
                chk("sat_count", 64'(sat0[k*16 +: 16]), 64'(m_sat0[k]));
                chk("sat_count_c1", 64'(sat1[k*16 +: 16]), 64'(m_sat1[k]));
            end
`endif
            if (ov0 && out_ready) begin
                log_id.push_back(int'(oid0));
                log_d0.push_back(od0);
                log_d1.push_back(od1);
                log_last.push_back(ol0);
                log_cyc.push_back(cyc);
            end

            n_locked = m_locked; n_grant = m_grant; n_ptr = m_ptr; n_ov = m_ov;
            n_d0 = m_d0; n_d1 = m_d1; n_id = m_id; n_last = m_last;
            a_vec = e_rdy & req_valid;
            if (!m_locked && req_valid != 4'b0) begin
                n_grant = m_ptr;
                while (!req_valid[n_grant]) n_grant = (n_grant + 1) % N;
                n_locked = 1;
            end
            if (a_vec != 4'b0) begin
                m_din  = req_data[m_grant*24 +: 24];
                n_ov   = 1;
                n_d0   = cr(m_din, 0);
                n_d1   = cr(m_din, 1);
                n_id   = m_grant;
                n_last = req_last[m_grant];
                n_inc0 = is_sat(n_d0);
                n_inc1 = is_sat(n_d1);
                if (req_last[m_grant]) begin
                    n_locked = 0;
                    n_ptr    = (m_grant + 1) % N;
                end
            end else if (out_ready) begin
                n_ov = 0;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_locked <= 0; m_grant <= 0; m_ptr <= 0; m_ov <= 0;
            m_d0 <= '0; m_d1 <= '0; m_id <= 0; m_last <= 0;
            for (int k = 0; k < 4; k++) begin
                m_sat0[k] <= 0;
                m_sat1[k] <= 0;
            end
        end else begin
            m_locked <= n_locked; m_grant <= n_grant; m_ptr <= n_ptr; m_ov <= n_ov;
            m_d0 <= n_d0; m_d1 <= n_d1; m_id <= n_id; m_last <= n_last;
            if (n_inc0 && m_sat0[n_id] < 65535) m_sat0[n_id] <= m_sat0[n_id] + 1;
            if (n_inc1 && m_sat1[n_id] < 65535) m_sat1[n_id] <= m_sat1[n_id] + 1;
        end
    end

    // Stimulus: per-requester sample queues.
    logic [23:0] qd [4][$];
    bit          ql [4][$];

    task automatic push(input int k, input logic [23:0] d, input bit l);
        qd[k].push_back(d);
        ql[k].push_back(l);
    endtask

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            req_valid[k] = qd[k].size() > 0;
            req_data[k*24 +: 24] = (qd[k].size() > 0) ? qd[k][0] : 24'h0;
            req_last[k] = (ql[k].size() > 0) ? ql[k][0] : 1'b0;
        end
    endtask

    task automatic clear_log();
        log_id.delete(); log_d0.delete(); log_d1.delete(); log_last.delete(); log_cyc.delete();
    endtask

    // Runs until every queue is drained and the output is empty, or stops early after
    // stop_after cycles. out_ready is low during cycles [st_start, st_start+st_len).
    task automatic run(input int max_cyc, input int st_start, input int st_len,
                       input int stop_after);
        int n;
        bit done;
        logic [3:0] acc;
        n = 0;
        done = 0;
        drive();
        while (!done && n < max_cyc && (stop_after < 0 || n < stop_after)) begin
            @(negedge clk);
            acc = req_valid & rdy0;
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                if (acc[k]) begin
                    void'(qd[k].pop_front());
                    void'(ql[k].pop_front());
                end
            end
            n++;
            out_ready = !(n >= st_start && n < st_start + st_len);
            drive();
            done = 1;
            for (int k = 0; k < 4; k++) if (qd[k].size() > 0) done = 0;
            if (ov0) done = 0;
        end
        if (stop_after < 0) chk("run_drained", 64'(done), 64'd1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_out_valid"}, 64'({ov0, ov1}), 64'd0);
        chk({tag, "_req_ready"}, 64'({rdy0, rdy1}), 64'd0);
        chk({tag, "_out_data"}, 64'({od0, od1}), 64'd0);
        chk({tag, "_out_id"}, 64'({oid0, oid1}), 64'd0);
        chk({tag, "_out_last"}, 64'({ol0, ol1}), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        req_valid = '0; req_last = '0; req_data = '0; out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            qd[k].delete();
            ql[k].delete();
        end
        #1 check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Pin the reference arithmetic.
        chk("model_cr_a", 64'(cr(24'h001200, 0)), 64'h0012);
        chk("model_cr_b", 64'(cr(24'h001200, 1)), 64'h0024);
        chk("model_cr_c", 64'(cr(24'h7FFFC0, 0)), 64'h7FFF);
        chk("model_cr_d", 64'(cr(24'hFFFF80, 1)), 64'hFFFF);

        #2 do_reset();

        // Single sample with exact cycle timing.
        req_valid = 4'b0001; req_last = 4'b0001; req_data[23:0] = 24'h001200;
        #1 chk("single_ready_idle", 64'(rdy0), 64'd0);
        @(posedge clk); #1;
        chk("single_ready_grant", 64'(rdy0), 64'b0001);
        @(posedge clk); #1;
        chk("single_out_valid", 64'(ov0), 64'd1);
        chk("single_out_data", 64'(od0), 64'h0012);
        chk("single_out_data_c1", 64'(od1), 64'h0024);
        chk("single_out_id", 64'(oid0), 64'd0);
        chk("single_out_last", 64'(ol0), 64'd1);
        chk("single_ready_after", 64'(rdy0), 64'd0);
        req_valid = '0; req_last = '0;
        @(posedge clk); #1;
        chk("single_out_drained", 64'(ov0), 64'd0);

        // Round robin from a fresh pointer.
        do_reset();
        clear_log();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 4; k++) push(k, 24'((k << 16) | (r << 8)), 1);
        run(200, 0, 0, -1);
        chk("rr_count", 64'(log_id.size()), 64'd8);
        if (log_id.size() == 8) begin
            for (int i = 0; i < 5; i++) chk("rr_order", 64'(log_id[i]), 64'(i % 4));
            for (int i = 0; i < 4; i++) chk("rr_gap", 64'(log_cyc[i+1] - log_cyc[i]), 64'd2);
        end

        // Burst lock: move the pointer to 2, then requester 2 bursts while 1 waits.
        push(1, 24'h100000, 1);
        run(100, 0, 0, -1);
        clear_log();
        for (int s = 0; s < 5; s++) push(2, 24'h210000 + 24'(s << 8), s == 4);
        push(1, 24'h110000, 1);
        run(200, 0, 0, -1);
        chk("lock_count", 64'(log_id.size()), 64'd6);
        if (log_id.size() == 6) begin
            for (int i = 0; i < 5; i++) begin
                chk("lock_id", 64'(log_id[i]), 64'd2);
                chk("lock_data", 64'(log_d0[i]), 64'h2100 + 64'(i));
            end
            chk("lock_last", 64'(log_last[4]), 64'd1);
            chk("lock_back_to_back", 64'(log_cyc[4] - log_cyc[0]), 64'd4);
            chk("lock_then_id", 64'(log_id[5]), 64'd1);
            chk("lock_then_data", 64'(log_d0[5]), 64'h1100);
        end

        // Backpressure mid-burst with sequence-numbered data.
        clear_log();
        for (int s = 0; s < 6; s++) push(2, 24'h220000 + 24'(s << 8), s == 5);
        run(200, 3, 3, -1);
        chk("bp_count", 64'(log_d0.size()), 64'd6);
        if (log_d0.size() == 6)
            for (int i = 0; i < 6; i++) chk("bp_seq", 64'(log_d0[i]), 64'h2200 + 64'(i));

        // Saturation and rounding-overflow corners.
        clear_log();
        push(0, 24'h7FFF00, 0);
        push(0, 24'h800000, 0);
        push(0, 24'h7FFFC0, 0);
        push(0, 24'hFFFF80, 1);
        run(200, 0, 0, -1);
        chk("sat_count_n", 64'(log_d0.size()), 64'd4);
        if (log_d0.size() == 4) begin
            chk("sat_pos", 64'(log_d0[0]), 64'h7FFF);
            chk("sat_neg", 64'(log_d0[1]), 64'h8000);
            chk("sat_round_ovf", 64'(log_d0[2]), 64'h7FFF);
            chk("round_neg_half", 64'(log_d0[3]), 64'h0000);
            chk("sat_pos_c1", 64'(log_d1[0]), 64'h7FFF);
            chk("sat_neg_c1", 64'(log_d1[1]), 64'h8000);
            chk("sat_round_ovf_c1", 64'(log_d1[2]), 64'h7FFF);
            chk("round_neg_c1", 64'(log_d1[3]), 64'hFFFF);
        end
`ifdef CLIP_ROUND_SCHED_STATS_EN
        chk("sat_counter_lit", 64'(sat0[15:0]), 64'd3);
        chk("sat_counter_lit_c1", 64'(sat1[15:0]), 64'd3);
`endif

        // Reset in the middle of requester 3's burst.
        for (int s = 0; s < 6; s++) push(3, 24'h330000 + 24'(s << 8), s == 5);
        run(100, 0, 0, 4);
        #2 do_reset();
        clear_log();
        push(3, 24'h0B0000, 1);
        push(0, 24'h0A0000, 1);
        run(100, 0, 0, -1);
        chk("rst_count", 64'(log_id.size()), 64'd2);
        if (log_id.size() == 2) begin
            chk("rst_first_id", 64'(log_id[0]), 64'd0);
            chk("rst_first_data", 64'(log_d0[0]), 64'h0A00);
            chk("rst_second_id", 64'(log_id[1]), 64'd3);
        end

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clip_round_sched.md
# clip_round_sched

Round-robin scheduler that time-shares one `clip_and_round` instance among `NUM_REQ` sample streams, for example several DDC/DUC channels narrowing accumulator outputs to 16 bits. It arbitrates valid/ready requesters, holds the grant for whole bursts delimited by `last`, and registers the narrowed result with the source ID. It honours downstream backpressure. It sits between the per-channel accumulators and the packing/FIFO stage.

## Interface

**Parameters**
- `NUM_REQ`, 4: number of requesters (2..8).
- `bits_in`, 24: input sample width.
- `bits_out`, 16: output sample width.
- `clip_bits`, 0: MSBs saturated away, passed to `clip_and_round`.
- `ID_W`, 2: width of the source ID; must satisfy 2^`ID_W` >= `NUM_REQ`.

**Ports**
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `req_valid`, in, `NUM_REQ`: per-requester sample valid.
- `req_last`, in, `NUM_REQ`: last sample of a burst.
- `req_data`, in, `NUM_REQ*bits_in`: requester k occupies bits [k*bits_in +: bits_in].
- `req_ready`, out, `NUM_REQ`: one-hot or zero; asserted only for the granted requester.
- `out_valid`, out, 1: registered result valid.
- `out_data`, out, `bits_out`: clipped and rounded sample.
- `out_id`, out, `ID_W`: source requester index.
- `out_last`, out, 1: copy of `req_last` of the source sample.
- `out_ready`, in, 1: downstream accept.

## Operation

**Core**
- One combinational `clip_and_round` with the same parameters. Its input is `req_data` muxed by the current grant.
- The block owns the output register; it has an enable and does not use the free-running registered variant.

**Handshake**
- `accept_k = req_valid[k] & req_ready[k]`.
- `req_ready[g] = grant_active & (!out_valid | out_ready)`.
- On accept, the output register loads data, ID and last, and `out_valid` sets.
- `out_valid` clears on `out_valid & out_ready` with no new accept in the same cycle.

**FSM**
- `IDLE`: if any `req_valid` is high, pick the first requester at or after `rr_ptr`, scanning upward with wrap. Register the grant and go to `LOCK`.
  - `req_ready` is 0 in `IDLE`, so grant selection costs one cycle per burst.
  - If no request is pending, stay in `IDLE`.
- `LOCK`: serve grant `g` only. On accept with `req_last[g]`=1, set `rr_ptr <= (g+1) mod NUM_REQ` and go to `IDLE`.
  - Deasserting `req_valid[g]` mid-burst does not release the grant; the burst must end with `last`.
- Other requesters never see `req_ready` while locked. Their `req_valid`/`req_data` must stay stable until they are served.

**Arithmetic**
- Output equals `clip_and_round(in)` bit-exactly: saturate `clip_bits` MSBs, then round away `bits_in-bits_out-clip_bits` LSBs.

## Timing

- **Reset values** (while `rst_n` low, asynchronously): `out_valid`=0, `out_data`=0, `out_id`=0, `out_last`=0, `req_ready`=0, FSM=`IDLE`, `rr_ptr`=0, statistics counters=0.
- **Latency:** sample accepted at edge N appears on `out_*` after edge N, valid in cycle N+1.
- **Throughput:** one sample per cycle within a burst while `out_ready`=1. Each burst costs one extra `IDLE` cycle.
- **Backpressure:** with `out_valid`=1 and `out_ready`=0, all `req_ready` are 0 and `out_*` hold stable.
- **Simultaneous drain and accept:** `out_valid` stays 1 and new data replaces old.
- **Reset mid-burst:** the burst is abandoned and the grant is lost. After release, arbitration restarts from requester 0.

## Configuration

- `CLIP_ROUND_SCHED_STATS_EN`
- **Defined:**
  - Adds output `sat_count`, `NUM_REQ*16` bits: per-requester counters, requester k at [k*16 +: 16].
  - Counter k increments on each accepted sample from k whose result equals the max positive code (2^(bits_out-1)-1) or the min code (-2^(bits_out-1)).
  - Counters saturate at 0xFFFF and clear on reset only.
- **Undefined:** the port and counters are absent; all other behaviour is identical.

## Test plan

- **Single sample:** requester 0 sends `0x001200` with `last`=1, `out_ready`=1 → `req_ready[0]` high one cycle after `req_valid`; next cycle `out_data`=0x0012, `out_id`=0, `out_last`=1.
- **Round-robin:** all 4 requesters hold single-sample bursts → service order 0,1,2,3,0; `out_id` sequence matches, one idle cycle between samples.
- **Burst lock:** requester 2 sends a 5-sample burst (last on sample 5) while requester 1 is requesting → five consecutive outputs with `out_id`=2, then requester 1 is served.
- **Backpressure:** hold `out_ready`=0 for 3 cycles mid-burst → `req_ready` low and `out_data` stable for 3 cycles; no sample lost or duplicated, verified by sequence-numbered data.
- **Saturation (`clip_bits`=1):** input `0x7FFF00` → output 0x7FFF; input `0x800000` → output 0x8000; with STATS_EN, `sat_count` for that requester = 2.
- **Reset mid-burst:** pulse `rst_n` low during requester 3's burst → all outputs 0 immediately; after release, requester 0 (if requesting) wins first.
